// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic {FS_RUN, FS_HOLD} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch FIFO; flush beats push and pop, head holds last value when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t head_q, head_d;
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = head_q;
  always_comb begin
    do_pop  = pop && !flush && !empty;
    do_push = push && !flush && (!full || do_pop);
    rptr_d  = flush ? '0 : rptr_q + AW'(do_pop);
    wptr_d  = flush ? '0 : wptr_q + AW'(do_push);
    cnt_d   = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // the word being written this edge becomes the head when it lands in the slot the head moves to
    head_d  = cnt_d == '0 ? head_q : (do_push && wptr_q == rptr_d) ? wdata : mem_q[rptr_d];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, always-enabled instruction port and prefetch queue with valid/ready, pause and redirect.
// Optional push counter port fetch_count when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16
) (
  input  logic        mem_Clk,
  input  logic        mem_Rst,
  input  logic        pause,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_memory_en,
  output logic [31:0] instruction_memory_a,
  input  logic [31:0] instruction_memory_v,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);
  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ADDR_W) - 64'd1);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic push, pop, full, empty;
  fetch_entry_t wdata, head;
  assign instruction_memory_en = 1'b1;
  assign instruction_memory_a  = pc_q;
  assign if_valid = !empty;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign wdata    = '{pc: pc_q, instr: instruction_memory_v};
  always_comb begin
    pop     = if_valid && if_ready;
    push    = state_q == FS_RUN && !pause && !redirect_valid && (!full || pop);
    // a redirect empties the queue, so only pause can keep the FSM in HOLD after it
    state_d = (pause || (!redirect_valid && full && !pop)) ? FS_HOLD : FS_RUN;
    pc_d    = redirect_valid ? (redirect_pc & ~32'h3 & ADDR_MASK)
            : push ? ((pc_q + INSTR_BYTES) & ADDR_MASK) : pc_q;
  end
  always_ff @(posedge mem_Clk or posedge mem_Rst) begin
    if (mem_Rst) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC & ADDR_MASK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  assign fetch_count = fetch_count_q;
  always_comb fetch_count_d = fetch_count_q + 32'(push);
  always_ff @(posedge mem_Clk or posedge mem_Rst) begin
    if (mem_Rst) fetch_count_q <= '0;
    else fetch_count_q <= fetch_count_d;
  end
`endif
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk  (mem_Clk),
    .rst  (mem_Rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(wdata),
    .full (full),
    .empty(empty),
    .head (head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic mem_Clk = 0, mem_Rst = 1, pause = 0, redirect_valid = 0, if_ready = 1;
  logic [31:0] redirect_pc = 0;
  logic mem_en, if_valid;
  logic [31:0] mem_a, mem_v, if_instr, if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  always #5 mem_Clk = ~mem_Clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .ADDR_W(16)) dut (
    .mem_Clk(mem_Clk), .mem_Rst(mem_Rst), .pause(pause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction_memory_en(mem_en), .instruction_memory_a(mem_a),
    .instruction_memory_v(mem_v), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count)
`endif
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a == 32'h0  ? 32'hA0A0_0001 : a == 32'h4 ? 32'hB0B0_0002 :
           a == 32'h8  ? 32'hC0C0_0003 : a == 32'hC ? 32'hD0D0_0004 :
           a == 32'h20 ? 32'hFFFF_FFFF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction
  assign mem_v = mem_en ? mem_rd(mem_a) : 32'hFFFF_FFFF;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t mq[$];
  logic [31:0] m_pc, m_lpc, m_linstr, m_cnt;
  bit m_hold;

  task automatic model_reset();
    mq.delete();
    m_pc = 0; m_lpc = 0; m_linstr = 0; m_cnt = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit p, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop, full, push;
    pop  = mq.size() != 0 && rdy;
    full = mq.size() == DEPTH;
    if (rv) begin
      mq.delete();
      m_pc = rpc & ~32'h3 & MASK;
      m_hold = p;
    end else begin
      push = !m_hold && !p && (!full || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{m_pc, mem_rd(m_pc)});
        m_pc = (m_pc + 4) & MASK;
        m_cnt++;
      end
      m_hold = p || (full && !pop);
    end
    if (mq.size() != 0) begin
      m_lpc = mq[0].pc;
      m_linstr = mq[0].instr;
    end
  endtask

  task automatic model_check();
    chk("valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
    chk("if_pc", if_pc, m_lpc);
    chk("if_instr", if_instr, m_linstr);
    chk("mem_a", mem_a, m_pc);
    chk("mem_en", {31'b0, mem_en}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic cyc(input bit p, input bit rv, input logic [31:0] rpc, input bit rdy);
    pause = p; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
    model_step(p, rv, rpc, rdy);
    @(posedge mem_Clk);
    #1;
    model_check();
  endtask

  typedef struct {
    bit p; bit rv; logic [31:0] rpc; bit rdy;
    bit ev; logic [31:0] epc; logic [31:0] ea;
  } vec_t;
  vec_t vt[23];

  initial begin
    vt[0]  = '{0,0,0,1, 1,32'h0,32'h4};
    vt[1]  = '{0,0,0,1, 1,32'h4,32'h8};
    vt[2]  = '{0,0,0,1, 1,32'h8,32'hC};
    vt[3]  = '{0,0,0,1, 1,32'hC,32'h10};
    vt[4]  = '{0,0,0,0, 1,32'hC,32'h14};
    vt[5]  = '{0,0,0,0, 1,32'hC,32'h14};
    vt[6]  = '{0,0,0,0, 1,32'hC,32'h14};
    vt[7]  = '{0,0,0,1, 1,32'h10,32'h14};
    vt[8]  = '{0,0,0,1, 1,32'h14,32'h18};
    vt[9]  = '{0,0,0,0, 1,32'h14,32'h1C};
    vt[10] = '{0,1,32'h103,0, 0,32'h14,32'h100};
    vt[11] = '{0,0,0,0, 1,32'h100,32'h104};
    vt[12] = '{1,0,0,1, 0,32'h100,32'h104};
    vt[13] = '{1,0,0,1, 0,32'h100,32'h104};
    vt[14] = '{1,0,0,1, 0,32'h100,32'h104};
    vt[15] = '{0,0,0,1, 0,32'h100,32'h104};
    vt[16] = '{0,0,0,1, 1,32'h104,32'h108};
    vt[17] = '{0,1,32'hFFFE,1, 0,32'h104,32'hFFFC};
    vt[18] = '{0,0,0,1, 1,32'hFFFC,32'h0};
    vt[19] = '{0,0,0,1, 1,32'h0,32'h4};
    vt[20] = '{1,1,32'h40,1, 0,32'h0,32'h40};
    vt[21] = '{0,0,0,1, 0,32'h0,32'h40};
    vt[22] = '{0,0,0,1, 1,32'h40,32'h44};

    model_reset();
    repeat (2) @(posedge mem_Clk);
    #1;
    chk("rst_a", mem_a, 32'h0);
    chk("rst_en", {31'b0, mem_en}, 32'd1);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    mem_Rst = 0;

    for (int i = 0; i < 23; i++) begin
      cyc(vt[i].p, vt[i].rv, vt[i].rpc, vt[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vt[i].ev});
      chk($sformatf("vec%0d_pc", i), if_pc, vt[i].epc);
      chk($sformatf("vec%0d_a", i), mem_a, vt[i].ea);
    end
    chk("stream_instr_0x40", if_instr, mem_rd(32'h40));

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    #3;
    mem_Rst = 1;
    #1;
    chk("async_rst_a", mem_a, 32'h0);
    chk("async_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("async_rst_pc", if_pc, 32'h0);
    chk("async_rst_instr", if_instr, 32'h0);
    chk("async_rst_en", {31'b0, mem_en}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("async_rst_count", fetch_count, 32'h0);
`endif
    model_reset();
    @(posedge mem_Clk);
    #1;
    mem_Rst = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("after_rst_a", mem_a, 32'h14);
`ifdef FETCH_PERF_EN
    chk("after_rst_count", fetch_count, 32'd5);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom % 2 == 0) ? ($urandom % 64) : ($urandom % 3 == 0) ? (32'hFFF0 + $urandom % 16) : $urandom;
      cyc($urandom % 8 == 0, $urandom % 16 == 0, t, $urandom % 4 != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
